square_pipelined: RTL and testbench

Pipelined unsigned integer squarer, the inverse companion of the pipelined square-root block in the fixed-point arithmetic library. It accepts one INPUT_BITS operand per cycle and returns its exact 2*INPUT_BITS square after a fixed latency of INPUT_BITS cycles. It uses one shift-add stage per operand bit and a global-stall valid/ready handshake, so it can feed and verify the square-root pipeline in round-trip benches.

---
 rtl/square_pipelined_pkg.sv | 9 +
 rtl/square_pipelined_stage.sv | 50 +++++
 rtl/square_pipelined.sv | 64 ++++++
 tb/tb_square_pipelined.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/square_pipelined_pkg.sv
// Shared helpers for the pipelined squarer.
// out_bits(): width of the exact square of an in_bits-wide unsigned operand.
package square_pipelined_pkg;

  function automatic int out_bits(input int in_bits);
    return 2 * in_bits;
  endfunction

endpackage

// File: rtl/square_pipelined_stage.sv
// One shift-add stage of the pipelined squarer.
// Adds partial product (x[STAGE] ? x << STAGE : 0) to the incoming accumulator.
// Ports:
//   clk, reset_n         clock, async active-low reset
//   advance              global enable; every register holds when low
//   valid_in/x_in/acc_in previous stage contents (stage 0: start/value/0)
//   valid_out/x_out/acc_out registered stage contents
module square_stage
  import square_pipelined_pkg::*;
#(
  parameter int INPUT_BITS = 16,
  parameter int STAGE      = 0,
  localparam int OUTPUT_BITS = out_bits(INPUT_BITS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   advance,
  input  logic                   valid_in,
  input  logic [INPUT_BITS-1:0]  x_in,
  input  logic [OUTPUT_BITS-1:0] acc_in,
  output logic                   valid_out,
  output logic [INPUT_BITS-1:0]  x_out,
  output logic [OUTPUT_BITS-1:0] acc_out
);

  logic                   r_valid;
  logic [INPUT_BITS-1:0]  r_x;
  logic [OUTPUT_BITS-1:0] r_acc;
  logic [OUTPUT_BITS-1:0] w_pp;

  // Zero-extend before shifting so no operand bits fall off the top.
  assign w_pp = x_in[STAGE] ? (OUTPUT_BITS'(x_in) << STAGE) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_x     <= '0;
      r_acc   <= '0;
    end else if (advance) begin
      r_valid <= valid_in;
      r_x     <= x_in;
      r_acc   <= acc_in + w_pp;
    end
  end

  assign valid_out = r_valid;
  assign x_out     = r_x;
  assign acc_out   = r_acc;

endmodule

// File: rtl/square_pipelined.sv
// Pipelined unsigned squarer: one operand per cycle, exact square after
// INPUT_BITS cycles. A single global advance freezes every stage when the
// last stage holds an unconsumed result (bubbles are not squeezed out).
// Ports:
//   clk, reset_n  clock, async active-low reset
//   start, value  operand valid / operand, taken when start && in_ready
//   in_ready      pipeline advances this cycle
//   out_ready     downstream takes square this cycle
//   data_valid    square holds a valid result
//   square        value*value, 2*INPUT_BITS wide
module square_pipelined
  import square_pipelined_pkg::*;
#(
  parameter int INPUT_BITS = 16,
  localparam int OUTPUT_BITS = out_bits(INPUT_BITS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [INPUT_BITS-1:0]  value,
  output logic                   in_ready,
  input  logic                   out_ready,
  output logic                   data_valid,
  output logic [OUTPUT_BITS-1:0] square
);

  // Index 0 is the pipe input, index k+1 is the output of stage k.
  logic [INPUT_BITS:0]                  w_vld_pipe;
  logic [INPUT_BITS:0][INPUT_BITS-1:0]  w_x_pipe;
  logic [INPUT_BITS:0][OUTPUT_BITS-1:0] w_acc_pipe;
  logic                                 w_advance;
  logic                                 w_unused;

  assign w_advance     = !w_vld_pipe[INPUT_BITS] || out_ready;
  assign in_ready      = w_advance;

  assign w_vld_pipe[0] = start;
  assign w_x_pipe[0]   = value;
  assign w_acc_pipe[0] = '0;

  for (genvar k = 0; k < INPUT_BITS; k++) begin : g_stage
    square_stage #(
      .INPUT_BITS(INPUT_BITS),
      .STAGE     (k)
    ) u_stage (
      .clk      (clk),
      .reset_n  (reset_n),
      .advance  (w_advance),
      .valid_in (w_vld_pipe[k]),
      .x_in     (w_x_pipe[k]),
      .acc_in   (w_acc_pipe[k]),
      .valid_out(w_vld_pipe[k+1]),
      .x_out    (w_x_pipe[k+1]),
      .acc_out  (w_acc_pipe[k+1])
    );
  end

  // The operand copy leaving the last stage has no consumer.
  assign w_unused   = ^w_x_pipe[INPUT_BITS];

  assign data_valid = w_vld_pipe[INPUT_BITS];
  assign square     = w_acc_pipe[INPUT_BITS];

endmodule

// File: tb/tb_square_pipelined.sv
module tb_square_pipelined;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, out_ready, in_ready, data_valid;
  logic [15:0] value;
  logic [31:0] square;

  logic       s5, or5, rdy5, dv5;
  logic [4:0] v5;
  logic [9:0] sq5;
  logic       s1, or1, rdy1, dv1;
  logic [0:0] v1;
  logic [1:0] sq1;

  int checks = 0;
  int failures = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  square_pipelined #(.INPUT_BITS(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .value(value),
    .in_ready(in_ready), .out_ready(out_ready),
    .data_valid(data_valid), .square(square));

  square_pipelined #(.INPUT_BITS(5)) dut5 (
    .clk(clk), .reset_n(reset_n), .start(s5), .value(v5),
    .in_ready(rdy5), .out_ready(or5),
    .data_valid(dv5), .square(sq5));

  square_pipelined #(.INPUT_BITS(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(s1), .value(v1),
    .in_ready(rdy1), .out_ready(or1),
    .data_valid(dv1), .square(sq1));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard: every accepted operand must come back squared, in order.
  always @(negedge clk) begin
    if (!reset_n) sb_q.delete();
    else begin
      if (data_valid && out_ready) begin
        if (sb_q.size() == 0) chk("sb_spurious_result", 1, 0);
        else chk("sb_data", square, sb_q.pop_front());
      end
      if (start && in_ready) sb_q.push_back(32'(value) * 32'(value));
    end
  end

  typedef struct {
    logic [15:0] v;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[11];

  task automatic run_single(input logic [15:0] v, input logic [31:0] exp);
    int lat;
    @(posedge clk); #1;
    start = 1'b1; value = v; out_ready = 1'b1;
    @(posedge clk); #1;          // accepting edge
    start = 1'b0;
    lat = 1;
    while (!data_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("single_latency", lat, 16);
    chk("single_square", square, exp);
  endtask

  task automatic drain(input string nm);
    start = 1'b0; out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk({nm, "_queue_empty"}, sb_q.size(), 0);
    chk({nm, "_idle_valid"}, data_valid, 0);
  endtask

  initial begin
    int l5, l1;
    logic took, stale;

    tbl[0]  = '{16'd0,     32'd0};
    tbl[1]  = '{16'd65535, 32'd4294836225};
    tbl[2]  = '{16'd1,     32'd1};
    tbl[3]  = '{16'd3,     32'd9};
    tbl[4]  = '{16'd255,   32'd65025};
    tbl[5]  = '{16'd256,   32'd65536};
    tbl[6]  = '{16'h8000,  32'd1073741824};
    tbl[7]  = '{16'hAAAA,  32'd1908816100};
    tbl[8]  = '{16'h5555,  32'd477204025};
    tbl[9]  = '{16'd12345, 32'd152399025};
    tbl[10] = '{16'd1000,  32'd1000000};

    reset_n = 1'b0; start = 1'b0; value = '0; out_ready = 1'b0;
    s5 = 1'b0; v5 = '0; or5 = 1'b1; s1 = 1'b0; v1 = '0; or1 = 1'b1;
    #1;
    chk("reset_data_valid", data_valid, 0);
    chk("reset_square", square, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_dv5", dv5, 0);
    chk("reset_dv1", dv1, 0);
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;

    // Table-driven single operands
    for (int i = 0; i < 11; i++) run_single(tbl[i].v, tbl[i].exp);

    // Streaming 1..16, results back-to-back starting at the 16th edge
    @(posedge clk); #1;
    start = 1'b1; value = 16'd1; out_ready = 1'b1;
    for (int i = 0; i < 31; i++) begin
      @(posedge clk); #1;
      if (i < 15) value = 16'(i + 2); else start = 1'b0;
      if (i >= 15) begin
        chk("stream_valid", data_valid, 1);
        chk("stream_square", square, (i - 14) * (i - 14));
      end
    end
    drain("stream");

    // Backpressure with a full pipe
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      value = 16'($urandom);
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    value = 16'hBEEF;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valid", data_valid, 1);
      chk("stall_square", square, sb_q[0]);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    drain("backpressure");

    // Random traffic with random backpressure
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk);
      took = start && in_ready;
      @(posedge clk); #1;
      if (!start || took) begin
        start = ($urandom_range(0, 3) != 0);
        value = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
    end
    drain("random");

    // Reset mid-flight with valid results in the pipe
    start = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      value = 16'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("pre_reset_valid", data_valid, 1);
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("midreset_valid", data_valid, 0);
    chk("midreset_square", square, 0);
    chk("midreset_in_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk); #2;
    reset_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (data_valid) stale = 1'b1;
    end
    chk("post_reset_no_stale", stale, 0);
    run_single(16'd7, 32'd49);

    // Odd widths: 5 bits and 1 bit
    @(posedge clk); #1;
    s5 = 1'b1; v5 = 5'd31; s1 = 1'b1; v1 = 1'b1;
    @(posedge clk); #1;
    s5 = 1'b0; s1 = 1'b0;
    l5 = 0; l1 = 0;
    for (int e = 1; e <= 10; e++) begin
      if (dv5 && l5 == 0) begin l5 = e; chk("w5_square", sq5, 961); end
      if (dv1 && l1 == 0) begin l1 = e; chk("w1_square", sq1, 1); end
      @(posedge clk); #1;
    end
    chk("w5_latency", l5, 5);
    chk("w1_latency", l1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
